day03_joltage_stream: RTL
=========================

// Module: day03_joltage_stream
// PURPOSE
// - Streaming max-K-digit selector and accumulator for Day 3 (parts 1 and 2 from one RTL).
// - Per line, keeps the K digits that form the largest K-digit subsequence, in original order.
// - At end of line, converts that subsequence to binary and adds it to a running total.
// - Sits behind the ASCII line parser; takes one digit per cycle with a valid/ready handshake.
// PARAMETERS
// - K         12  digits kept per line (>=1); K=2 is part 1, K=12 is part 2.
// - RESULT_W  64  width of total and line value; elaboration error if 10**K-1 >= 2**RESULT_W.
// - CNT_W     16  width of the line counter.
// PORTS
// - clk_i       in   1         clock, rising edge
// - rst_i       in   1         synchronous reset, active-high
// - valid_i     in   1         input beat valid
// - ready_o     out  1         beat accepted when valid_i && ready_o
// - digit_i     in   4         digit 0..9; ignored on eol beats
// - eol_i       in   1         beat is end-of-line (carries no digit)
// - result_o    out  RESULT_W  running sum of line values
// - lines_o     out  CNT_W     number of completed lines
// - err_o       out  1         sticky: a digit beat had digit_i > 9
// BEHAVIOUR
// - Reset (rst_i=1 at an edge): state=IDLE, B[K-1:0]=0, fill=0, result_o=0, lines_o=0,
//   err_o=0, ready_o=1 from the next cycle. Reset mid-line or mid-CONVERT discards all work.
// - States: IDLE (accept beats) -> CONVERT (K cycles) -> ADD (1 cycle) -> IDLE.
// - ready_o=1 only in IDLE. Back-pressure keeps inputs stable; a beat is taken on handshake only.
// - Digit beat (eol_i=0, digit d<=9), one per cycle, no stall:
//   - fill<K: shift B up by one (B[0]=d); fill++.
//   - fill==K: j = the highest i with B[i]<B[i-1]; if none, j=0.
//     C = B with position j removed, digits below j shifted up by one, C[0]=d.
//     B <= (C > B as K-digit numbers) ? C : B. Ties keep B.
// - Digit beat with d>9: beat is consumed, B and fill unchanged, err_o<=1.
// - EOL beat: go to CONVERT; idx=K-1, acc=0.
//   A line with fewer than K digits has zeros in the upper digits (value = digits seen).
//   An empty line adds 0.
// - CONVERT: acc <= acc*10 + B[idx]; idx--. Leave after idx=0, which takes exactly K cycles.
// - ADD: result_o += acc (modulo 2**RESULT_W); lines_o++ (wraps); B=0; fill=0; go to IDLE.
// - Latency: EOL accepted at edge t -> result_o/lines_o update at edge t+K+1;
//   ready_o=0 for K+1 cycles.
// - Beats presented while ready_o=0 are not consumed; the source holds them.
// - Arithmetic: acc is RESULT_W wide; *10 is done as (acc<<3)+(acc<<1); no carry out kept.
// CONFIGURATION
// - DAY03_LINE_OUT_EN defined:
//   - adds ports line_valid_o (1b) and line_value_o (RESULT_W).
//   - line_valid_o pulses for exactly the ADD cycle with line_value_o=acc.
//   - Both reset to 0; line_value_o holds its last value.
// - DAY03_LINE_OUT_EN undefined: neither port exists; all other behaviour is identical.
// TESTING
// - K=12, lines 987654321111111, 811111111111119, 234234234234278, 818181911112111
//   -> result_o=3121910778619, lines_o=4.
// - K=2, same four lines -> line values 98, 89, 78, 92; result_o=357.
// - K=4, line "12" then EOL -> line value 12; empty line (EOL only) -> +0, lines_o increments.
// - K=3, line 5,A,9,7,1 (A = 4'hA) -> err_o=1 and stays 1; line value 971.
// - Hold valid_i=1 with a digit beat during CONVERT -> not consumed until ready_o=1;
//   count ready_o low cycles == K+1.
// - Assert rst_i in the 3rd CONVERT cycle -> result_o=0, lines_o=0;
//   the next line is computed from scratch.

Source files
------------

// File: rtl/day03_joltage_stream_if.sv
// Digit-stream handshake between the line parser (master) and the joltage selector (slave).
interface day03_joltage_stream_if;
    logic       valid_i;
    logic       ready_o;
    logic [3:0] digit_i;
    logic       eol_i;

    modport master (output valid_i, output digit_i, output eol_i, input ready_o);
    modport slave  (input valid_i, input digit_i, input eol_i, output ready_o);
endinterface

// File: rtl/day03_joltage_stream.sv
// Keeps the largest K-digit subsequence of each line and sums the line values; DAY03_LINE_OUT_EN adds a per-line output.
// Latency: one digit per cycle; EOL accepted at edge t updates result_o/lines_o at edge t+K+1.
// Backpressure: ready_o is high only in IDLE, so it drops for the K+1 cycles of CONVERT and ADD.
module day03_joltage_stream #(
    parameter int K        = 12,
    parameter int RESULT_W = 64,
    parameter int CNT_W    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    day03_joltage_stream_if.slave   in_if,
    output logic [RESULT_W-1:0]     result_o,
    output logic [CNT_W-1:0]        lines_o,
    output logic                    err_o
`ifdef DAY03_LINE_OUT_EN
    ,
    output logic                    line_valid_o,
    output logic [RESULT_W-1:0]     line_value_o
`endif
);

    // Bits needed to hold 10**k - 1, evaluated at elaboration.
    function automatic int unsigned max_val_bits(input int unsigned k);
        logic [255:0] p;
        int unsigned  n;
        p = 256'd1;
        for (int unsigned i = 0; i < k; i++) p = p * 256'd10;
        p = p - 256'd1;
        n = 0;
        for (int unsigned i = 0; i < 256; i++) if (p[i]) n = i + 1;
        return n;
    endfunction

    localparam int FILL_W = $clog2(K + 1);
    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;

    if (K < 1) begin : g_k_chk
        $error("day03_joltage_stream: K must be at least 1");
    end
    if (max_val_bits(K) > RESULT_W) begin : g_width_chk
        $error("day03_joltage_stream: RESULT_W too narrow for 10**K-1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_ADD
    } state_e;

    state_e              state_q, state_d;
    logic [4*K-1:0]      b_q;
    logic [4*K-1:0]      b_shift;
    logic [4*K-1:0]      cand;
    logic [4*K-1:0]      b_at_idx;
    logic [FILL_W-1:0]   fill_q;
    logic [IDX_W-1:0]    idx_q;
    logic [RESULT_W-1:0] acc_q;
    logic [RESULT_W-1:0] acc_next;
    logic [3:0]          cur_digit;
    int unsigned         rm_pos;
    logic                beat;

    assign in_if.ready_o = (state_q == S_IDLE);
    assign beat          = in_if.valid_i && in_if.ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (beat && in_if.eol_i) state_d = S_CONVERT;
            S_CONVERT: if (idx_q == '0) state_d = S_ADD;
            S_ADD:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Drop the most significant digit that is smaller than its lower neighbour
    // (or the lowest digit if the number is non-increasing), then append the new digit.
    always_comb begin
        rm_pos = 0;
        for (int i = 1; i < K; i++) begin
            if (b_q[4*i +: 4] < b_q[4*(i-1) +: 4]) rm_pos = i;
        end
        cand = b_q;
        for (int i = 1; i < K; i++) begin
            if (i <= rm_pos) cand[4*i +: 4] = b_q[4*(i-1) +: 4];
        end
        cand[3:0] = in_if.digit_i;
    end

    always_comb begin
        b_shift      = b_q << 4;
        b_shift[3:0] = in_if.digit_i;
    end

    // BCD nibbles compare correctly as a plain binary vector.
    assign b_at_idx  = b_q >> {idx_q, 2'b00};
    assign cur_digit = b_at_idx[3:0];
    assign acc_next  = (acc_q << 3) + (acc_q << 1) + RESULT_W'(cur_digit);

`ifdef DAY03_LINE_OUT_EN
    assign line_valid_o = (state_q == S_ADD);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            b_q      <= '0;
            fill_q   <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_o <= '0;
            lines_o  <= '0;
            err_o    <= 1'b0;
`ifdef DAY03_LINE_OUT_EN
            line_value_o <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (beat) begin
                        if (in_if.eol_i) begin
                            idx_q <= IDX_W'(K - 1);
                            acc_q <= '0;
                        end else if (in_if.digit_i > 4'd9) begin
                            err_o <= 1'b1;
                        end else if (fill_q < FILL_W'(K)) begin
                            b_q    <= b_shift;
                            fill_q <= fill_q + FILL_W'(1);
                        end else if (cand > b_q) begin
                            b_q <= cand;
                        end
                    end
                end
                S_CONVERT: begin
                    acc_q <= acc_next;
                    idx_q <= idx_q - IDX_W'(1);
`ifdef DAY03_LINE_OUT_EN
                    if (idx_q == '0) line_value_o <= acc_next;
`endif
                end
                S_ADD: begin
                    result_o <= result_o + acc_q;
                    lines_o  <= lines_o + CNT_W'(1);
                    b_q      <= '0;
                    fill_q   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
